reg_file_lookup_pipe: RTL and testbench

Pipelined, multi-channel address-to-register lookup engine for the AXI-Lite user register file. It replaces the single-cycle combinational table search with a search split into P pipeline stages, so the table size no longer limits timing. It arbitrates several request channels (typically AXI read and AXI write) onto one pipeline using round-robin. It returns `reg_file_item_t` per request and counts decode misses. It sits between the AXI-Lite front end and the register storage/trigger logic.

---
 rtl/reg_file_pkg.sv | 72 +++++++
 rtl/reg_file_rr_arbiter.sv | 50 +++++
 rtl/reg_file_lookup_pipe.sv | 108 ++++++++++
 tb/tb_reg_file_lookup_pipe.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// Register-file shared types, the AXI-Lite register map table and the
// per-slice lookup helper used by the pipelined address decoder.
package reg_file_pkg;

   localparam int REG_FILE_AXI_ADDR_WIDTH        = 8;
   localparam int REG_FILE_NUM_REGISTERS         = 6;
   localparam int REG_FILE_ID_WIDTH              = $clog2(REG_FILE_NUM_REGISTERS);
   localparam int REG_FILE_LOOKUP_CHAN_WIDTH     = 8;
   localparam int REG_FILE_DEFAULT_CMP_PER_STAGE = 4;
   localparam int REG_FILE_LOOKUP_STAGES =
      (REG_FILE_NUM_REGISTERS + REG_FILE_DEFAULT_CMP_PER_STAGE - 1) / REG_FILE_DEFAULT_CMP_PER_STAGE;

   typedef enum logic [1:0] {
      REG_RO   = 2'd0,
      REG_RW   = 2'd1,
      REG_WO   = 2'd2,
      REG_TRIG = 2'd3
   } reg_access_e;

   typedef struct packed {
      logic [REG_FILE_AXI_ADDR_WIDTH-1:0] addr;
      reg_access_e                        access;
      logic [15:0]                        reset_val;
   } reg_file_entry_t;

   typedef struct packed {
      logic                         entry_found;
      logic [REG_FILE_ID_WIDTH-1:0] id;
      reg_file_entry_t              entry;
   } reg_file_item_t;

   typedef struct packed {
      logic                                  valid;
      logic [REG_FILE_LOOKUP_CHAN_WIDTH-1:0] chan;
      logic [REG_FILE_AXI_ADDR_WIDTH-1:0]    addr;
      reg_file_item_t                        item;
   } lookup_stage_t;

   // Entry 5 duplicates entry 4's address; lowest index shadows it.
   localparam reg_file_entry_t axi_lite_reg_map_table [REG_FILE_NUM_REGISTERS] = '{
      '{addr: 8'h00, access: REG_RO,   reset_val: 16'h0001},
      '{addr: 8'h04, access: REG_RW,   reset_val: 16'h0000},
      '{addr: 8'h08, access: REG_RW,   reset_val: 16'h00a5},
      '{addr: 8'h0c, access: REG_WO,   reset_val: 16'h0000},
      '{addr: 8'h10, access: REG_TRIG, reset_val: 16'h0000},
      '{addr: 8'h10, access: REG_RW,   reset_val: 16'hbeef}
   };

   function automatic reg_file_item_t slice_match(
      input logic [REG_FILE_AXI_ADDR_WIDTH-1:0] addr,
      input int unsigned                        slice,
      input int unsigned                        cmp_per_stage = REG_FILE_DEFAULT_CMP_PER_STAGE,
      input int unsigned                        lsb_ignore    = 2
   );
      reg_file_item_t r;
      int unsigned    idx;
      r = '0;
      for (int unsigned j = 0; j < cmp_per_stage; j++) begin
         idx = slice * cmp_per_stage + j;
         if (idx < REG_FILE_NUM_REGISTERS && !r.entry_found) begin
            if ((addr >> lsb_ignore) ==
                (axi_lite_reg_map_table[REG_FILE_ID_WIDTH'(idx)].addr >> lsb_ignore)) begin
               r.entry_found = 1'b1;
               r.id          = REG_FILE_ID_WIDTH'(idx);
               r.entry       = axi_lite_reg_map_table[REG_FILE_ID_WIDTH'(idx)];
            end
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/reg_file_rr_arbiter.sv
// Round-robin request arbiter; pointer moves past the granted channel on
// each accepted grant and freezes whenever adv is low.
module reg_file_rr_arbiter #(
   parameter int NUM_CHANNELS = 2
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_CHANNELS-1:0] req,
   input  logic                    adv,
   output logic [NUM_CHANNELS-1:0] grant
);

   localparam int PW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

   logic [PW-1:0]           ptr_q;
   logic [PW-1:0]           ptr_nxt;
   logic [NUM_CHANNELS-1:0] pick;
   logic                    found;

   // Two passes: channels at or above the pointer first, then the wrap-around.
   always_comb begin
      pick    = '0;
      found   = 1'b0;
      ptr_nxt = ptr_q;
      for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
         if (!found && c >= 32'(ptr_q) && req[c]) begin
            pick[c] = 1'b1;
            found   = 1'b1;
            ptr_nxt = PW'((c + 1) % NUM_CHANNELS);
         end
      end
      for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
         if (!found && c < 32'(ptr_q) && req[c]) begin
            pick[c] = 1'b1;
            found   = 1'b1;
            ptr_nxt = PW'((c + 1) % NUM_CHANNELS);
         end
      end
      grant = adv ? pick : '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= '0;
      end else if (adv && found) begin
         ptr_q <= ptr_nxt;
      end
   end

endmodule

// File: rtl/reg_file_lookup_pipe.sv
// Pipelined multi-channel address-to-register lookup: round-robin arbitration
// into P compare stages, one table slice per stage, with a saturating miss counter.
module reg_file_lookup_pipe
   import reg_file_pkg::*;
#(
   parameter int NUM_CHANNELS    = 2,
   parameter int CMP_PER_STAGE   = 4,
   parameter int ADDR_LSB_IGNORE = 2,
   parameter int MISS_CNT_WIDTH  = 16
) (
   input  logic                                            clk,
   input  logic                                            rst_n,
   input  logic [NUM_CHANNELS-1:0]                         in_valid,
   output logic [NUM_CHANNELS-1:0]                         in_ready,
   input  logic [NUM_CHANNELS*REG_FILE_AXI_ADDR_WIDTH-1:0] in_addr,
   output logic                                            out_valid,
   input  logic                                            out_ready,
   output reg_file_item_t                                  out_item,
   output logic [((NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1)-1:0] out_chan,
   output logic [REG_FILE_AXI_ADDR_WIDTH-1:0]              out_addr,
   input  logic                                            miss_clr,
   output logic [MISS_CNT_WIDTH-1:0]                       miss_cnt
);

   localparam int P  = (REG_FILE_NUM_REGISTERS + CMP_PER_STAGE - 1) / CMP_PER_STAGE;
   localparam int CW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
   localparam int AW = REG_FILE_AXI_ADDR_WIDTH;

   logic                    adv;
   logic [NUM_CHANNELS-1:0] grant;
   lookup_stage_t           head;
   lookup_stage_t           stage_d [P];
   lookup_stage_t           stage_q [P];
   lookup_stage_t           last;

   function automatic lookup_stage_t merge_hit(input lookup_stage_t s, input reg_file_item_t hit);
      lookup_stage_t r;
      r = s;
      if (s.valid && !s.item.entry_found) begin
         r.item = hit;
      end
      return r;
   endfunction

   assign last = stage_q[P-1];
   // rst_n gating keeps in_ready low while reset is held.
   assign adv  = (out_ready | ~last.valid) & rst_n;

   reg_file_rr_arbiter #(
      .NUM_CHANNELS(NUM_CHANNELS)
   ) u_arb (
      .clk  (clk),
      .rst_n(rst_n),
      .req  (in_valid),
      .adv  (adv),
      .grant(grant)
   );

   always_comb begin
      head = '0;
      for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
         if (grant[i]) begin
            head.valid = 1'b1;
            head.chan  = REG_FILE_LOOKUP_CHAN_WIDTH'(i);
            head.addr  = in_addr[i*AW +: AW];
         end
      end
   end

   for (genvar k = 0; k < P; k++) begin : g_stage
      if (k == 0) begin : g_head
         assign stage_d[k] = merge_hit(head,
            slice_match(head.addr, k, CMP_PER_STAGE, ADDR_LSB_IGNORE));
      end else begin : g_tail
         assign stage_d[k] = merge_hit(stage_q[k-1],
            slice_match(stage_q[k-1].addr, k, CMP_PER_STAGE, ADDR_LSB_IGNORE));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned k = 0; k < P; k++) begin
            stage_q[k] <= '0;
         end
      end else if (adv) begin
         for (int unsigned k = 0; k < P; k++) begin
            stage_q[k] <= stage_d[k];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         miss_cnt <= '0;
      end else if (miss_clr) begin
         miss_cnt <= '0;
      end else if (last.valid && out_ready && !last.item.entry_found && miss_cnt != '1) begin
         miss_cnt <= miss_cnt + 1'b1;
      end
   end

   assign in_ready  = grant;
   assign out_valid = last.valid;
   assign out_item  = last.item;
   assign out_chan  = last.chan[CW-1:0];
   assign out_addr  = last.addr;

endmodule

// File: tb/tb_reg_file_lookup_pipe.sv
// Directed and randomized bench for reg_file_lookup_pipe (2 channels, 2 compares
// per stage, 3 stages) against a cycle-level queue/array reference model.
module tb_reg_file_lookup_pipe;
   import reg_file_pkg::*;

   localparam int NCH = 2;
   localparam int CMP = 2;
   localparam int P   = 3;
   localparam int AW  = REG_FILE_AXI_ADDR_WIDTH;
   localparam int MW  = 16;

   logic               clk;
   logic               rst_n;
   logic [NCH-1:0]     in_valid;
   logic [NCH-1:0]     in_ready;
   logic [NCH*AW-1:0]  in_addr;
   logic               out_valid;
   logic               out_ready;
   reg_file_item_t     out_item;
   logic [0:0]         out_chan;
   logic [AW-1:0]      out_addr;
   logic               miss_clr;
   logic [MW-1:0]      miss_cnt;

   reg_file_lookup_pipe #(
      .NUM_CHANNELS   (NCH),
      .CMP_PER_STAGE  (CMP),
      .ADDR_LSB_IGNORE(2),
      .MISS_CNT_WIDTH (MW)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_addr  (in_addr),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_item (out_item),
      .out_chan (out_chan),
      .out_addr (out_addr),
      .miss_clr (miss_clr),
      .miss_cnt (miss_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_assert = 0;
   int n_fail   = 0;
   int tb_addr [6] = '{'h00, 'h04, 'h08, 'h0c, 'h10, 'h10};

   bit             m_valid [P];
   int             m_chan  [P];
   logic [AW-1:0]  m_addr  [P];
   int             m_ptr;
   logic [MW-1:0]  m_cnt;

   int             s_acc;
   logic [NCH-1:0] s_grant;
   bit             s_hs;
   logic           s_out_valid;
   reg_file_item_t s_item;
   logic [0:0]     s_chan;
   logic [AW-1:0]  s_addr;
   int             tick_no = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference decode: word-address compare, lowest table index wins.
   function automatic reg_file_item_t expect_item(input logic [AW-1:0] a);
      reg_file_item_t e;
      e = '0;
      for (int i = 5; i >= 0; i--) begin
         if ((int'(a) / 4) == (tb_addr[i] / 4)) begin
            e.entry_found = 1'b1;
            e.id          = REG_FILE_ID_WIDTH'(i);
            e.entry       = axi_lite_reg_map_table[i];
         end
      end
      return e;
   endfunction

   task automatic model_clear();
      for (int k = 0; k < P; k++) begin
         m_valid[k] = 1'b0;
         m_chan[k]  = 0;
         m_addr[k]  = '0;
      end
      m_ptr = 0;
      m_cnt = '0;
   endtask

   task automatic tick();
      int             c;
      bit             adv_m;
      logic [NCH-1:0] eg;
      reg_file_item_t ei;
      @(negedge clk);
      adv_m = out_ready || !m_valid[P-1];
      s_acc = -1;
      eg    = '0;
      ei    = '0;
      if (adv_m) begin
         for (int i = 0; i < NCH; i++) begin
            c = (m_ptr + i) % NCH;
            if (s_acc < 0 && in_valid[c]) s_acc = c;
         end
      end
      if (s_acc >= 0) eg[s_acc] = 1'b1;
      s_grant     = in_ready;
      s_out_valid = out_valid;
      s_item      = out_item;
      s_chan      = out_chan;
      s_addr      = out_addr;
      chk("in_ready", in_ready, eg);
      chk("out_valid", out_valid, m_valid[P-1]);
      s_hs = m_valid[P-1] && out_ready;
      if (m_valid[P-1]) begin
         ei = expect_item(m_addr[P-1]);
         chk("out_chan", out_chan, m_chan[P-1]);
         chk("out_addr", out_addr, m_addr[P-1]);
         chk("out_item", out_item, ei);
      end
      if (miss_clr) m_cnt = '0;
      else if (s_hs && !ei.entry_found && m_cnt != '1) m_cnt = m_cnt + 1'b1;
      if (adv_m) begin
         for (int k = P - 1; k > 0; k--) begin
            m_valid[k] = m_valid[k-1];
            m_chan[k]  = m_chan[k-1];
            m_addr[k]  = m_addr[k-1];
         end
         m_valid[0] = (s_acc >= 0);
         m_chan[0]  = 0;
         m_addr[0]  = '0;
         if (s_acc >= 0) begin
            m_chan[0] = s_acc;
            m_addr[0] = in_addr[s_acc*AW +: AW];
            m_ptr     = (s_acc + 1) % NCH;
         end
      end
      @(posedge clk);
      #1;
      chk("miss_cnt", miss_cnt, m_cnt);
      tick_no++;
   endtask

   task automatic apply_reset();
      rst_n    = 1'b0;
      in_valid = '1;
      miss_clr = 1'b0;
      #1;
      model_clear();
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_out_item", out_item, '0);
      chk("rst_out_chan", out_chan, 1'b0);
      chk("rst_out_addr", out_addr, '0);
      chk("rst_miss_cnt", miss_cnt, '0);
      chk("rst_in_ready", in_ready, 2'b00);
      in_valid = '0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic send_wait(input int ch, input logic [AW-1:0] a, input bit clr_at_out);
      int guard;
      guard    = 0;
      in_valid = '0;
      in_valid[ch] = 1'b1;
      in_addr[ch*AW +: AW] = a;
      do begin
         tick();
         guard++;
      end while (s_acc != ch && guard < 20);
      chk("accept", (s_acc == ch), 1'b1);
      in_valid = '0;
      repeat (P - 1) begin
         tick();
         chk("lat_idle", s_out_valid, 1'b0);
      end
      miss_clr = clr_at_out;
      tick();
      miss_clr = 1'b0;
      chk("lat_out", s_out_valid, 1'b1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [AW-1:0] bp_list [4];
      logic [AW-1:0] pool [12];
      logic [AW-1:0] got [$];
      int            oc [$];
      int            ot [$];
      int            idx;
      int            acc_n;
      bit            pend [NCH];
      logic [AW-1:0] paddr [NCH];

      rst_n     = 1'b0;
      in_valid  = '0;
      in_addr   = '0;
      out_ready = 1'b1;
      miss_clr  = 1'b0;
      apply_reset();

      // Basic hit
      send_wait(0, 8'h0c, 1'b0);
      chk("hit_found", s_item.entry_found, 1'b1);
      chk("hit_id", s_item.id, 3);
      chk("hit_chan", s_chan, 1'b0);

      // Duplicate entries and ignored LSBs
      send_wait(1, 8'h10, 1'b0);
      chk("dup_id", s_item.id, 4);
      chk("dup_chan", s_chan, 1'b1);
      send_wait(0, 8'h11, 1'b0);
      chk("dup_lsb_id", s_item.id, 4);

      // Miss counting with clear colliding with a counted miss
      for (int i = 1; i <= 3; i++) begin
         send_wait(0, 8'h40, 1'b0);
         chk("miss_found", s_item.entry_found, 1'b0);
         chk("miss_step", miss_cnt, i);
      end
      send_wait(0, 8'h40, 1'b1);
      chk("miss_clr_prio", miss_cnt, 0);

      // Arbitration
      apply_reset();
      out_ready = 1'b1;
      in_addr[0 +: AW]  = 8'h04;
      in_addr[AW +: AW] = 8'h08;
      for (int i = 0; i < 10; i++) begin
         in_valid = (i < 6) ? 2'b11 : 2'b00;
         tick();
         if (i < 6) chk("arb_grant", s_grant, (i % 2 == 0) ? 2'b01 : 2'b10);
         if (s_hs) begin
            oc.push_back(int'(s_chan));
            ot.push_back(tick_no);
         end
      end
      chk("arb_count", oc.size(), 6);
      for (int j = 0; j < oc.size(); j++) begin
         chk("arb_out_chan", oc[j], j % 2);
         chk("arb_b2b", ot[j], ot[0] + j);
      end

      // Backpressure
      bp_list = '{8'h00, 8'h0c, 8'h10, 8'h40};
      in_valid  = '0;
      out_ready = 1'b0;
      idx   = 0;
      acc_n = 0;
      for (int t = 0; t < 5; t++) begin
         in_valid[0] = (idx < 4);
         in_addr[0 +: AW] = bp_list[idx % 4];
         tick();
         if (s_acc == 0) begin
            idx++;
            acc_n++;
         end
         if (s_out_valid) chk("bp_hold_addr", s_addr, 8'h00);
      end
      chk("bp_accepted", acc_n, 3);
      chk("bp_in_ready", s_grant, 2'b00);
      out_ready = 1'b1;
      for (int t = 0; t < 12; t++) begin
         in_valid[0] = (idx < 4);
         in_addr[0 +: AW] = bp_list[idx % 4];
         tick();
         if (s_acc == 0) idx++;
         if (s_hs) got.push_back(s_addr);
      end
      in_valid = '0;
      chk("bp_drain_count", got.size(), 4);
      for (int j = 0; j < got.size() && j < 4; j++) chk("bp_order", got[j], bp_list[j]);

      // Reset mid-operation
      in_valid = 2'b10;
      in_addr[AW +: AW] = 8'h08;
      tick();
      tick();
      in_valid = 2'b11;
      rst_n    = 1'b0;
      #1;
      model_clear();
      chk("midrst_out_valid", out_valid, 1'b0);
      chk("midrst_in_ready", in_ready, 2'b00);
      chk("midrst_miss_cnt", miss_cnt, '0);
      repeat (2) @(posedge clk);
      #1;
      rst_n    = 1'b1;
      in_valid = '0;
      for (int t = 0; t < 6; t++) begin
         tick();
         chk("midrst_no_out", s_out_valid, 1'b0);
      end
      in_valid = 2'b11;
      tick();
      chk("midrst_ptr0", s_grant, 2'b01);
      in_valid = '0;

      // Randomized traffic
      pool = '{8'h00, 8'h04, 8'h08, 8'h0c, 8'h10, 8'h11, 8'h13, 8'h0d,
               8'h40, 8'h80, 8'hfc, 8'h14};
      for (int c = 0; c < NCH; c++) begin
         pend[c]  = 1'b0;
         paddr[c] = '0;
      end
      for (int t = 0; t < 400; t++) begin
         for (int c = 0; c < NCH; c++) begin
            if (!pend[c] && $urandom_range(0, 2) != 0) begin
               pend[c]  = 1'b1;
               paddr[c] = pool[$urandom_range(0, 11)];
            end
            in_valid[c] = pend[c];
            in_addr[c*AW +: AW] = paddr[c];
         end
         out_ready = ($urandom_range(0, 3) != 0);
         miss_clr  = ($urandom_range(0, 15) == 0);
         tick();
         if (s_acc >= 0) pend[s_acc] = 1'b0;
      end
      in_valid  = '0;
      miss_clr  = 1'b0;
      out_ready = 1'b1;
      repeat (P + 2) tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
